// File: rtl/awg_pkg.sv
// awg_pkg: shared sample type and playback state encoding for the waveform pacer.
package awg_pkg;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} pacer_state_t;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/strobe_div.sv
// strobe_div: free-running sample-period divider, ticks whenever the count is zero.
module strobe_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;
  assign o_tick = i_en && r_cnt == '0;
  // Held at zero while disabled so the first enabled cycle ticks immediately.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= !i_en || r_cnt == i_period - DIV_W'(1) ? '0 : r_cnt + DIV_W'(1);
endmodule

// File: rtl/sample_pacer.sv
// sample_pacer: plays a waveform from memory at a fixed sample period, then flushes zeros.
module sample_pacer import awg_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int DIV_W  = 16,
  parameter int FLUSH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] len,
  input  logic [DIV_W-1:0]  period,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  sample_t           mem_data,
  output sample_t           dout,
  output logic              cke,
  output logic              busy,
  output logic              done
);
  localparam int FC_W = $clog2(FLUSH + 2);
  pacer_state_t      r_state;
  logic [ADDR_W-1:0] r_len, r_addr;
  logic [DIV_W-1:0]  r_period;
  logic [FC_W-1:0]   r_fcnt;
  logic              r_stop, r_cke, r_zero, r_done;
  sample_t           r_dout;
  logic              w_tick, w_busy;
  assign w_busy   = r_state != S_IDLE;
  assign mem_rd   = r_state == S_RUN && w_tick && !r_stop;
  assign mem_addr = r_addr;
  // Read data arrives alongside the strobe, so it is passed through and captured for holding.
  assign dout     = r_cke ? (r_zero ? '0 : mem_data) : r_dout;
  assign cke      = r_cke;
  assign busy     = w_busy;
  assign done     = r_done;
  strobe_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst),
    .i_en     (w_busy),
    .i_period (r_period),
    .o_tick   (w_tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_addr   <= '0;
      r_period <= DIV_W'(MIN_PERIOD);
      r_fcnt   <= '0;
      r_stop   <= 1'b0;
      r_cke    <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_cke  <= 1'b0;
      r_done <= 1'b0;
      if (r_cke) r_dout <= dout;
      case (r_state)
        S_IDLE:
          if (start && len != '0) begin
            r_state  <= S_RUN;
            r_len    <= len;
            r_period <= period < DIV_W'(MIN_PERIOD) ? DIV_W'(MIN_PERIOD) : period;
            r_addr   <= '0;
            r_fcnt   <= '0;
            r_stop   <= 1'b0;
          end
        S_RUN: begin
          if (stop) r_stop <= 1'b1;
          if (w_tick && r_stop) r_state <= S_FLUSH;
          else if (w_tick) begin
            r_cke  <= 1'b1;
            r_zero <= 1'b0;
            if (r_addr == r_len - ADDR_W'(1)) begin
              r_addr <= '0;
              if (!loop_en) r_state <= S_FLUSH;
            end else r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_FLUSH:
          // Leave one cycle after the last tick so the final zero strobe is seen while busy.
          if (r_fcnt == FC_W'(FLUSH)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_tick) begin
            r_cke  <= 1'b1;
            r_zero <= 1'b1;
            r_fcnt <= r_fcnt + FC_W'(1);
          end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/sample_pacer.md
SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the waveform memory address width.
REQ-002 SHALL have parameter DIV_W, default 16, meaning the sample-period counter width.
REQ-003 SHALL have parameter FLUSH, default 4, meaning the number of zero samples emitted after playback ends.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock (rising edge); rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle playback request.
REQ-006 stop  input  1  one-cycle abort request.
REQ-007 loop_en  input  1  wrap to address 0 at end of waveform.
REQ-008 len  input  ADDR_W  number of samples in the waveform, latched at start.
REQ-009 period  input  DIV_W  clocks between output samples, latched at start.
REQ-010 mem_rd  output  1  memory read enable.
REQ-011 mem_addr  output  ADDR_W  memory read address.
REQ-012 mem_data  input  16 signed  memory read data, valid exactly one cycle after mem_rd.
REQ-013 dout  output  16 signed  sample to the interpolator din.
REQ-014 cke  output  1  one-cycle sample strobe to the interpolator cke.
REQ-015 busy  output  1  high in RUN or FLUSH.
REQ-016 done  output  1  one-cycle pulse on return to IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-018 IDLE: start=1 with len!=0 SHALL latch len and period, clear addr and divider, and enter RUN; start with len==0 SHALL be ignored.
REQ-019 A latched period below 2 SHALL be treated as 2.
REQ-020 The divider SHALL count 0..period-1 and wrap; a tick SHALL occur when the divider is 0.
REQ-021 RUN tick: mem_rd=1, mem_addr=addr; one cycle later dout<=mem_data and cke=1 for exactly one cycle.
REQ-022 Latency: start accepted in cycle T gives first mem_rd in T+1 and first cke in T+2; subsequent cke every period cycles.
REQ-023 dout SHALL hold its value between strobes.
REQ-024 After a read at addr==len-1: with loop_en=1, addr<=0 and RUN continues; otherwise the FSM SHALL enter FLUSH.
REQ-025 stop in RUN SHALL be registered as pending; the next tick SHALL enter FLUSH with no read issued.
REQ-026 FLUSH: each tick SHALL produce cke=1 with dout=0 one cycle later; mem_rd=0.
REQ-027 After FLUSH zero strobes the FSM SHALL enter IDLE and pulse done for one cycle.
REQ-028 start in RUN or FLUSH SHALL be ignored; stop in IDLE or FLUSH SHALL be ignored.
REQ-029 If start and stop are both high in IDLE, start SHALL win.
REQ-030 The last read coinciding with pending stop SHALL complete its strobe, then FLUSH.
REQ-031 Changes to len, period or loop_en inputs mid-playback SHALL have no effect, except loop_en, which SHALL be sampled at the last-address read.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, divider=0, addr=0, pending stop=0, mem_rd=0, mem_addr=0, dout=0, cke=0, busy=0, done=0.
REQ-033 Reset asserted mid-RUN or mid-FLUSH SHALL abort immediately with no done pulse.

Structure
REQ-034 Package awg_pkg SHALL hold the typedef sample_t (signed 16-bit) and the state enum pacer_state_t.
REQ-035 The divider/tick generator SHALL be a sub-module named strobe_div.

Verification
REQ-036 len=4, period=5, loop_en=0, memory {100,-200,300,-400}, FLUSH=4 -> cke at T+2, T+7, ..., dout 100,-200,300,-400,0,0,0,0; then done one cycle; busy low.
REQ-037 len=3, loop_en=1, period=3 -> dout sequence 100,-200,300,100,-200,... with no gap; stop -> exactly 4 zero strobes, then done.
REQ-038 period=0 and period=1 -> strobes every 2 cycles.
REQ-039 start with len=0 -> stays IDLE, no mem_rd, no cke, no done.
REQ-040 rst low during FLUSH -> all outputs 0 in the same cycle, no done; subsequent start replays from addr 0.
REQ-041 start held high throughout playback -> no restart; single done at end.
